// File: rtl/free_list_pkg.sv
// Shared rename-stage constants and types: register counts, tag and pointer widths,
// and the per-cycle dispatch/retire width used by the map table, ROB and free list.
package free_list_pkg;

    localparam int PR_NUM   = 64;
    localparam int AR_NUM   = 32;
    localparam int TAG_W    = 7;
    localparam int FL_DEPTH = PR_NUM - AR_NUM;
    localparam int PTR_W    = $clog2(FL_DEPTH);
    localparam int CNT_W    = $clog2(FL_DEPTH + 1);
    localparam int RN_WIDTH = 2;

    typedef logic [PTR_W-1:0]              ptr_t;
    typedef logic [TAG_W-1:0]              tag_t;
    typedef logic [$clog2(RN_WIDTH+1)-1:0] rn_num_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO handing out up to two tags per cycle at
// dispatch and reclaiming up to two retired tags; a squash rewinds head to tail in one cycle.
module free_list #(
    parameter int PR_NUM = free_list_pkg::PR_NUM,
    parameter int AR_NUM = free_list_pkg::AR_NUM,
    parameter int TAG_W  = free_list_pkg::TAG_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     rob_dispatch_num,
    input  logic [1:0]                     rob_retire_num,
    input  logic [TAG_W-1:0]               rob_p0told,
    input  logic [TAG_W-1:0]               rob_p1told,
    input  logic                           rob_squash,
    output logic [TAG_W-1:0]               fl_pr0,
    output logic [TAG_W-1:0]               fl_pr1,
    output logic [1:0]                     fl_avail,
    output logic [free_list_pkg::CNT_W-1:0] fl_count
);
    import free_list_pkg::*;

    localparam int DEPTH = PR_NUM - AR_NUM;

    logic [TAG_W-1:0] slot_q [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    rn_num_t          alloc_n;
    rn_num_t          free_n;
    ptr_t             tail_p1;
    ptr_t             head_p1;

    // Pointer advance with wrap at DEPTH; reduces to natural wrap when DEPTH is a power of two.
    function automatic ptr_t ptr_add(input ptr_t p, input rn_num_t n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    assign head_p1 = ptr_add(head_q, rn_num_t'(1));
    assign tail_p1 = ptr_add(tail_q, rn_num_t'(1));

    assign fl_pr0   = slot_q[head_q];
    assign fl_pr1   = slot_q[head_p1];
    assign fl_avail = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    assign fl_count = count_q;

    always_comb begin
        alloc_n = '0;
        free_n  = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        free_n = (rob_retire_num > 2'd2) ? rn_num_t'(2) : rn_num_t'(rob_retire_num);
        if (!rob_squash) begin
            alloc_n = (rob_dispatch_num > fl_avail) ? rn_num_t'(fl_avail)
                                                    : rn_num_t'(rob_dispatch_num);
        end

        tail_d = ptr_add(tail_q, free_n);
        if (rob_squash) begin
            // Slots [tail, head) still hold the in-flight tags, so rewinding head frees them in place.
            head_d  = tail_d;
            count_d = CNT_W'(DEPTH);
        end else begin
            head_d  = ptr_add(head_q, alloc_n);
            count_d = count_q + CNT_W'(free_n) - CNT_W'(alloc_n);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= TAG_W'(AR_NUM + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
        end else begin
            if (free_n != '0) begin
                slot_q[tail_q] <= rob_p0told;
            end
            if (free_n == rn_num_t'(2)) begin
                slot_q[tail_p1] <= rob_p1told;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a queue model of free and in-flight tags.
module tb_free_list;
    import free_list_pkg::*;

    logic       clock;
    logic       reset;
    logic [1:0] rob_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_p0told;
    logic [6:0] rob_p1told;
    logic       rob_squash;
    logic [6:0] fl_pr0;
    logic [6:0] fl_pr1;
    logic [1:0] fl_avail;
    logic [5:0] fl_count;

    int n_cmp;
    int n_err;

    // Model: fq is the free tags in hand-out order, iq the allocated tags oldest first.
    logic [6:0] fq[$];
    logic [6:0] iq[$];

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .rob_dispatch_num (rob_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_p0told       (rob_p0told),
        .rob_p1told       (rob_p1told),
        .rob_squash       (rob_squash),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_avail         (fl_avail),
        .fl_count         (fl_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) begin
            assert (rob_dispatch_num <= fl_avail)
                else $error("protocol: dispatch %0d above avail %0d", rob_dispatch_num, fl_avail);
            assert (32'(fl_count) + 32'(rob_retire_num) <= 32)
                else $error("protocol: retire %0d with count %0d", rob_retire_num, fl_count);
        end
    end

    task automatic model_reset();
        fq.delete();
        iq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(7'(32 + i));
    endtask

    task automatic model_step(input int disp, input int ret, input logic [6:0] t0,
                              input logic [6:0] t1, input bit sq);
        int d;
        d = sq ? 0 : disp;
        if (d > fq.size()) d = fq.size();
        for (int k = 0; k < d; k++) iq.push_back(fq.pop_front());
        for (int k = 0; k < ret; k++) begin
            void'(iq.pop_front());
            fq.push_back(k == 0 ? t0 : t1);
        end
        if (sq) begin
            fq = {iq, fq};
            iq.delete();
        end
    endtask

    task automatic cycle(input int disp, input int ret, input logic [6:0] t0,
                         input logic [6:0] t1, input bit sq);
        rob_dispatch_num = 2'(disp);
        rob_retire_num   = 2'(ret);
        rob_p0told       = t0;
        rob_p1told       = t1;
        rob_squash       = sq;
        @(posedge clock);
        model_step(disp, ret, t0, t1, sq);
        @(negedge clock);
        rob_dispatch_num = 2'd0;
        rob_retire_num   = 2'd0;
        rob_p0told       = 7'd0;
        rob_p1told       = 7'd0;
        rob_squash       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (fl_pr0 !== 7'd32) begin n_err++; $display("FAIL reset_pr0: got %0d want 32", fl_pr0); end
        n_cmp++; if (fl_pr1 !== 7'd33) begin n_err++; $display("FAIL reset_pr1: got %0d want 33", fl_pr1); end
        n_cmp++; if (fl_count !== 6'd32) begin n_err++; $display("FAIL reset_count: got %0d want 32", fl_count); end
        n_cmp++; if (fl_avail !== 2'd2) begin n_err++; $display("FAIL reset_avail: got %0d want 2", fl_avail); end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 7'd0, 7'd0, 1'b0);
            n_cmp++;
            if (fl_pr0 !== 7'd32 || fl_pr1 !== 7'd33 || fl_count !== 6'd32) begin
                n_err++;
                $display("FAIL idle_stable: got %0d/%0d/%0d want 32/33/32", fl_pr0, fl_pr1, fl_count);
            end
        end
    endtask

    task automatic test_dispatch_steps();
        int          disp [3]  = '{2, 1, 2};
        logic [6:0]  want0 [3] = '{7'd34, 7'd35, 7'd37};
        logic [6:0]  want1 [3] = '{7'd35, 7'd36, 7'd38};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            cycle(disp[s], 0, 7'd0, 7'd0, 1'b0);
            n_cmp++;
            if (fl_pr0 !== want0[s] || fl_pr1 !== want1[s]) begin
                n_err++;
                $display("FAIL steps_%0d: got %0d/%0d want %0d/%0d", s, fl_pr0, fl_pr1, want0[s], want1[s]);
            end
        end
        n_cmp++; if (fl_count !== 6'd27) begin n_err++; $display("FAIL steps_count: got %0d want 27", fl_count); end
    endtask

    task automatic test_drain_wrap();
        do_reset();
        for (int c = 0; c < 16; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        n_cmp++; if (fl_count !== 6'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", fl_count); end
        n_cmp++; if (fl_avail !== 2'd0) begin n_err++; $display("FAIL drain_avail: got %0d want 0", fl_avail); end
        cycle(0, 2, 7'd3, 7'd4, 1'b0);
        n_cmp++;
        if (fl_pr0 !== 7'd3 || fl_pr1 !== 7'd4) begin
            n_err++;
            $display("FAIL wrap_tags: got %0d/%0d want 3/4", fl_pr0, fl_pr1);
        end
        n_cmp++; if (fl_avail !== 2'd2) begin n_err++; $display("FAIL wrap_avail: got %0d want 2", fl_avail); end
    endtask

    task automatic test_simul();
        do_reset();
        for (int c = 0; c < 11; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        n_cmp++; if (fl_count !== 6'd10) begin n_err++; $display("FAIL simul_pre_count: got %0d want 10", fl_count); end
        cycle(2, 2, 7'd5, 7'd6, 1'b0);
        n_cmp++; if (fl_count !== 6'd10) begin n_err++; $display("FAIL simul_count: got %0d want 10", fl_count); end
        n_cmp++; if (fl_pr0 !== 7'd56) begin n_err++; $display("FAIL simul_pr0: got %0d want 56", fl_pr0); end
        for (int c = 0; c < 4; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        n_cmp++;
        if (fl_pr0 !== 7'd5 || fl_pr1 !== 7'd6 || fl_count !== 6'd2) begin
            n_err++;
            $display("FAIL simul_surface: got %0d/%0d cnt %0d want 5/6 cnt 2", fl_pr0, fl_pr1, fl_count);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int c = 0; c < 3; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        cycle(0, 2, 7'd2, 7'd3, 1'b0);
        n_cmp++; if (fl_count !== 6'd28) begin n_err++; $display("FAIL squash_pre_count: got %0d want 28", fl_count); end
        cycle(2, 0, 7'd0, 7'd0, 1'b1);
        n_cmp++; if (fl_count !== 6'd32) begin n_err++; $display("FAIL squash_count: got %0d want 32", fl_count); end
        n_cmp++;
        if (fl_pr0 !== 7'd34 || fl_pr1 !== 7'd35) begin
            n_err++;
            $display("FAIL squash_head: got %0d/%0d want 34/35", fl_pr0, fl_pr1);
        end
        for (int c = 0; c < 15; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        n_cmp++;
        if (fl_pr0 !== 7'd2 || fl_pr1 !== 7'd3 || fl_count !== 6'd2) begin
            n_err++;
            $display("FAIL squash_tail: got %0d/%0d cnt %0d want 2/3 cnt 2", fl_pr0, fl_pr1, fl_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 5; c++) cycle(2, 0, 7'd0, 7'd0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (fl_pr0 !== 7'd32 || fl_pr1 !== 7'd33 || fl_count !== 6'd32) begin
            n_err++;
            $display("FAIL async_reset: got %0d/%0d/%0d want 32/33/32", fl_pr0, fl_pr1, fl_count);
        end
        @(negedge clock);
        reset = 1'b1;
        cycle(1, 0, 7'd0, 7'd0, 1'b0);
        n_cmp++;
        if (fl_pr0 !== 7'd33 || fl_count !== 6'd31) begin
            n_err++;
            $display("FAIL async_resume: got %0d cnt %0d want 33 cnt 31", fl_pr0, fl_count);
        end
    endtask

    task automatic test_random();
        int  dmax, rmax, d, r;
        bit  fill, sq;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            dmax = (fq.size() < 2) ? fq.size() : 2;
            rmax = (iq.size() < 2) ? iq.size() : 2;
            d    = int'($urandom_range(dmax, 0));
            r    = int'($urandom_range(rmax, 0));
            fill = ((c / 120) % 2) == 1;
            if (fill && $urandom_range(2, 0) != 0) d = 0;
            if (!fill && $urandom_range(2, 0) != 0) r = 0;
            sq   = ($urandom_range(59, 0) == 0);
            cycle(d, r, 7'($urandom_range(127, 0)), 7'($urandom_range(127, 0)), sq);
            n_cmp++;
            if (fl_count !== 6'(fq.size())) begin
                n_err++;
                $display("FAIL rand_count @%0d: got %0d want %0d", c, fl_count, fq.size());
            end
            n_cmp++;
            if (fl_avail !== 2'((fq.size() < 2) ? fq.size() : 2)) begin
                n_err++;
                $display("FAIL rand_avail @%0d: got %0d want %0d", c, fl_avail, (fq.size() < 2) ? fq.size() : 2);
            end
            if (fq.size() >= 1) begin
                n_cmp++;
                if (fl_pr0 !== fq[0]) begin
                    n_err++;
                    $display("FAIL rand_pr0 @%0d: got %0d want %0d", c, fl_pr0, fq[0]);
                end
            end
            if (fq.size() >= 2) begin
                n_cmp++;
                if (fl_pr1 !== fq[1]) begin
                    n_err++;
                    $display("FAIL rand_pr1 @%0d: got %0d want %0d", c, fl_pr1, fq[1]);
                end
            end
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        reset            = 1'b1;
        rob_dispatch_num = 2'd0;
        rob_retire_num   = 2'd0;
        rob_p0told       = 7'd0;
        rob_p1told       = 7'd0;
        rob_squash       = 1'b0;
        model_reset();

        test_reset();
        test_dispatch_steps();
        test_drain_wrap();
        test_simul();
        test_squash();
        test_async_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the 2-wide rename stage. It is a circular FIFO of physical register tags that supplies up to two new tags per cycle (`fl_pr0`, `fl_pr1`) to the map table and ROB at dispatch. It reclaims up to two old tags per cycle (`Told`) when the ROB retires instructions. On a full pipeline squash it restores itself to the committed state in one cycle.

## Interface
Parameters:
- `PR_NUM`, default 64: number of physical registers.
- `AR_NUM`, default 32: number of architected registers. At reset, AR i maps to PR i.
- `TAG_W`, default 7: physical tag width, matching the map table.
- `FL_DEPTH`, derived as `PR_NUM-AR_NUM` (32): FIFO slots.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `rob_dispatch_num`, input, 2: tags consumed this cycle (0, 1 or 2).
- `rob_retire_num`, input, 2: tags freed this cycle (0, 1 or 2).
- `rob_p0told`, input, `TAG_W`: first freed tag. Written first.
- `rob_p1told`, input, `TAG_W`: second freed tag. Meaningful only when `rob_retire_num`==2.
- `rob_squash`, input, 1: full flush of all in-flight instructions.
- `fl_pr0`, output, `TAG_W`: tag at head.
- `fl_pr1`, output, `TAG_W`: tag at head+1.
- `fl_avail`, output, 2: min(count, 2). Dispatch must stall above this.
- `fl_count`, output, 6: number of free tags (0..`FL_DEPTH`).

## Operation
- State:
  - `slot[FL_DEPTH]` of `TAG_W` bits.
  - `head` and `tail`, 5-bit pointers with natural mod-32 wrap.
  - `count`, 6-bit.
- Invariant: free + in-flight allocations == `FL_DEPTH`.
  - Slots [tail, head) always hold the tags allocated to in-flight instructions.
  - No slot is ever overwritten while its tag is still free.
- Reset (asynchronous, while `reset`==0):
  - `slot[i]` = `AR_NUM`+i.
  - `head`=0, `tail`=0, `count`=`FL_DEPTH`.
  - Therefore `fl_pr0`=32, `fl_pr1`=33, `fl_avail`=2, `fl_count`=32.
- Allocate: `head` += d, where d = min(`rob_dispatch_num`, `fl_avail`).
  - `rob_dispatch_num` > `fl_avail` is a protocol error. The block clamps to `fl_avail`, and the bench asserts it never happens.
- Free:
  - `slot[tail]` <= `rob_p0told` when r ≥ 1, where r = `rob_retire_num`.
  - `slot[tail+1]` <= `rob_p1told` when r == 2.
  - `tail` += r.
  - A retire that would push `count` above `FL_DEPTH` is a protocol error (it implies no in-flight instruction). It is asserted.
- Count update, no squash: `count` <= `count` + r − d.
- Squash (`rob_squash`==1):
  - Retire writes and the `tail` advance still happen that cycle.
  - Dispatch is ignored.
  - `head` <= new `tail`.
  - `count` <= `FL_DEPTH`.
  - Every in-flight tag returns to free in its original slot, with no copying.
- Outputs:
  - `fl_pr0` = `slot[head]`.
  - `fl_pr1` = `slot[head+1]`.
  - When `count` < 2, the upper output carries stale data. Only `fl_avail` qualifies it.

## Timing
- `fl_pr0`, `fl_pr1`, `fl_avail` and `fl_count` are combinational from registered state only. They have no input-to-output path and are valid early in the cycle for rename.
- All state updates at posedge `clock`, so allocation latency is 0 cycles (tags are visible before the edge that consumes them).
- A tag freed in cycle N first appears on `fl_pr*` in cycle N+1. There is no free-to-alloc bypass, even when the FIFO is empty.
- Simultaneous dispatch and retire in one cycle:
  - Both apply.
  - They touch disjoint slots by the invariant.
  - Count applies the net delta.
- Wrap: `head+1` and `tail+1` wrap modulo `FL_DEPTH`. Slot 31 is followed by slot 0.
- Empty (`count`==0): `fl_avail`=0. Retire in the same cycle gives `fl_avail`≥1 on the next cycle.
- Squash and reset both win over dispatch. Reset deasserted mid-sequence resumes from the reset state at the next edge.

## Structure
- The shared rename package holds:
  - `PR_NUM`, `AR_NUM`, `TAG_W`, `FL_DEPTH`;
  - the 5-bit pointer type and the tag type, shared with `mt` and the ROB;
  - the dispatch/retire width constant (2).
- Single module. No sub-module is warranted; the slot array is a flop array with two write ports and two read ports.

## Test plan
- Reset, then idle: `fl_pr0`=32, `fl_pr1`=33, `fl_count`=32. These values stay stable with `rob_dispatch_num`=0.
- Dispatch 2, 1, 2 on consecutive cycles: outputs step 32/33 → 34/35 → 35/36 → 37/38; `fl_count` ends at 27.
- Dispatch 2 every cycle for 16 cycles: count reaches 0 and `fl_avail`=0. Then retire 2 with `Told`=3,4: the next cycle gives `fl_pr0`=3, `fl_pr1`=4 (the wrap slots 0/1 are reused).
- Same cycle dispatch 2 and retire 2 (`Told`=5,6) with count=10: count stays 10. Tags 5 and 6 surface after the existing free entries, at the correct pointer offset.
- Dispatch 6 tags (32..37), retire 2 (`Told`=2,3), then assert `rob_squash`: the next cycle gives `fl_count`=32, `fl_pr0`=34 (the first unretired allocation), with 2 and 3 at the tail.
- Assert reset asynchronously mid-operation (between edges): outputs immediately return to 32/33/32.
